// File: rtl/uart_digit_rx.sv
// uart_digit_rx: 8N1 UART receiver for the pixel-clock domain. Every byte
// with a good stop bit is published on rx_byte. ASCII '0'..'9' also update
// the 5-bit digit code num, which the HDMI digit-display stage reads directly.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | line idle; waiting for a falling edge on rx_s
// S_START | timing to mid start bit; a high sample there is a false start
// S_DATA  | sampling 8 data bits LSB first, one bit period apart
// S_STOP  | sampling mid stop bit; high publishes the byte, low is a framing error
// S_BREAK | after a framing error; waits for the line to return high
//
// CLKS_PER_BIT must be at least 8 so that the half-bit point is well defined.
module uart_digit_rx #(
  parameter int CLK_FREQ = 74_250_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       Rst,
  input  logic       uart_rx,
  output logic [4:0] num,
  output logic       num_valid,
  output logic [7:0] rx_byte,
  output logic       rx_byte_valid,
  output logic       frame_err
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int TMR_W        = $clog2(CLKS_PER_BIT);
  localparam logic [TMR_W-1:0] TMR_HALF = TMR_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TMR_W-1:0] TMR_FULL = TMR_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t           state_q, state_d;
  logic             rx_meta_q, rx_s_q;
  logic [TMR_W-1:0] bit_tmr_q, bit_tmr_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [4:0]       num_q, num_d;
  logic             num_valid_q, num_valid_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic             rx_byte_valid_q, rx_byte_valid_d;
  logic             frame_err_q, frame_err_d;

  // Two-flop synchroniser; resets to the idle-high line level so that
  // reset release never looks like a start bit.
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // State, bit timing and output registers.
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state_q         <= S_IDLE;
      bit_tmr_q       <= '0;
      bit_idx_q       <= '0;
      shift_q         <= '0;
      num_q           <= '0;
      num_valid_q     <= 1'b0;
      rx_byte_q       <= '0;
      rx_byte_valid_q <= 1'b0;
      frame_err_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      bit_tmr_q       <= bit_tmr_d;
      bit_idx_q       <= bit_idx_d;
      shift_q         <= shift_d;
      num_q           <= num_d;
      num_valid_q     <= num_valid_d;
      rx_byte_q       <= rx_byte_d;
      rx_byte_valid_q <= rx_byte_valid_d;
      frame_err_q     <= frame_err_d;
    end
  end

  // Next-state and output decode. The stop sample falls at mid-stop-bit, so
  // returning to idle there leaves half a bit of margin for a back-to-back
  // start edge.
  always_comb begin
    state_d         = state_q;
    bit_tmr_d       = bit_tmr_q + TMR_W'(1);
    bit_idx_d       = bit_idx_q;
    shift_d         = shift_q;
    num_d           = num_q;
    num_valid_d     = 1'b0;
    rx_byte_d       = rx_byte_q;
    rx_byte_valid_d = 1'b0;
    frame_err_d     = frame_err_q;

    unique case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          bit_tmr_d = '0;
          state_d   = S_START;
        end
      end

      S_START: begin
        if (bit_tmr_q == TMR_HALF) begin
          if (rx_s_q) begin
            state_d = S_IDLE;
          end else begin
            bit_tmr_d = '0;
            bit_idx_d = '0;
            state_d   = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (bit_tmr_q == TMR_FULL) begin
          shift_d[bit_idx_q] = rx_s_q;
          bit_tmr_d          = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end

      S_STOP: begin
        if (bit_tmr_q == TMR_FULL) begin
          if (rx_s_q) begin
            rx_byte_d       = shift_q;
            rx_byte_valid_d = 1'b1;
            frame_err_d     = 1'b0;
            if ((shift_q >= 8'h30) && (shift_q <= 8'h39)) begin
              num_d       = {1'b0, shift_q[3:0]};
              num_valid_d = 1'b1;
            end
            state_d = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end
      end

      S_BREAK: begin
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign num           = num_q;
  assign num_valid     = num_valid_q;
  assign rx_byte       = rx_byte_q;
  assign rx_byte_valid = rx_byte_valid_q;
  assign frame_err     = frame_err_q;

endmodule

// File: tb/tb_uart_digit_rx.sv
// Directed bench for uart_digit_rx at default parameters (644 clocks per bit).
module tb_uart_digit_rx;

  localparam int CPB = 74_250_000 / 115200;

  logic       clk;
  logic       Rst;
  logic       uart_rx;
  logic [4:0] num;
  logic       num_valid;
  logic [7:0] rx_byte;
  logic       rx_byte_valid;
  logic       frame_err;

  int tests_run    = 0;
  int tests_failed = 0;

  int cyc       = 0;
  int nv_cnt    = 0;
  int rbv_cnt   = 0;
  int consec    = 0;
  int unpaired  = 0;
  bit nv_prev   = 0;
  bit rbv_prev  = 0;
  int nv_times[$];
  int nv_vals[$];

  int nv0, rb0, idx0;

  uart_digit_rx dut (
    .clk          (clk),
    .Rst          (Rst),
    .uart_rx      (uart_rx),
    .num          (num),
    .num_valid    (num_valid),
    .rx_byte      (rx_byte),
    .rx_byte_valid(rx_byte_valid),
    .frame_err    (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (num_valid) begin
      nv_cnt = nv_cnt + 1;
      nv_times.push_back(cyc);
      nv_vals.push_back(int'(num));
      if (!rx_byte_valid) unpaired = unpaired + 1;
    end
    if (rx_byte_valid) rbv_cnt = rbv_cnt + 1;
    if ((num_valid && nv_prev) || (rx_byte_valid && rbv_prev)) consec = consec + 1;
    nv_prev  = num_valid;
    rbv_prev = rx_byte_valid;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run = tests_run + 1;
    if (got !== exp) begin
      tests_failed = tests_failed + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives one frame starting at the current falling edge; the line is left
  // at the stop-bit level afterwards.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic snap();
    nv0 = nv_cnt;
    rb0 = rbv_cnt;
  endtask

  initial begin
    uart_rx = 1'b1;
    Rst     = 1'b1;
    repeat (4) @(negedge clk);
    check_val("rst_num", num, 0);
    check_val("rst_num_valid", num_valid, 0);
    check_val("rst_rx_byte", rx_byte, 0);
    check_val("rst_rx_byte_valid", rx_byte_valid, 0);
    check_val("rst_frame_err", frame_err, 0);
    Rst = 1'b0;
    repeat (20) @(negedge clk);

    // '7'
    snap();
    send_frame(8'h37, 1'b1);
    repeat (20) @(negedge clk);
    check_val("d7_num", num, 7);
    check_val("d7_rx_byte", rx_byte, 8'h37);
    check_val("d7_frame_err", frame_err, 0);
    check_val("d7_nv_pulses", nv_cnt - nv0, 1);
    check_val("d7_rbv_pulses", rbv_cnt - rb0, 1);

    // 'A' leaves num alone
    snap();
    send_frame(8'h41, 1'b1);
    repeat (20) @(negedge clk);
    check_val("a_rx_byte", rx_byte, 8'h41);
    check_val("a_num", num, 7);
    check_val("a_nv_pulses", nv_cnt - nv0, 0);
    check_val("a_rbv_pulses", rbv_cnt - rb0, 1);

    // False start: 100-cycle low glitch
    snap();
    uart_rx = 1'b0;
    repeat (100) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2000) @(negedge clk);
    check_val("fs_num", num, 7);
    check_val("fs_rx_byte", rx_byte, 8'h41);
    check_val("fs_frame_err", frame_err, 0);
    check_val("fs_nv_pulses", nv_cnt - nv0, 0);
    check_val("fs_rbv_pulses", rbv_cnt - rb0, 0);

    // 0x35 with bad stop bit, then break held low
    snap();
    send_frame(8'h35, 1'b0);
    repeat (5000) @(negedge clk);
    check_val("fe_frame_err", frame_err, 1);
    check_val("fe_num", num, 7);
    check_val("fe_rx_byte", rx_byte, 8'h41);
    check_val("fe_rbv_pulses", rbv_cnt - rb0, 0);
    uart_rx = 1'b1;
    repeat (1000) @(negedge clk);

    // '2' clears the framing error
    snap();
    send_frame(8'h32, 1'b1);
    repeat (20) @(negedge clk);
    check_val("d2_num", num, 2);
    check_val("d2_frame_err", frame_err, 0);
    check_val("d2_rx_byte", rx_byte, 8'h32);
    check_val("d2_nv_pulses", nv_cnt - nv0, 1);

    // '1','9' back to back
    snap();
    idx0 = nv_times.size();
    send_frame(8'h31, 1'b1);
    send_frame(8'h39, 1'b1);
    repeat (20) @(negedge clk);
    check_val("b2b_nv_pulses", nv_cnt - nv0, 2);
    if (nv_times.size() >= idx0 + 2) begin
      check_val("b2b_first_num", nv_vals[idx0], 1);
      check_val("b2b_second_num", nv_vals[idx0+1], 9);
      check_val("b2b_spacing", nv_times[idx0+1] - nv_times[idx0], 10 * CPB);
    end
    check_val("b2b_num", num, 9);

    // Reset during data bit 4 of '8' (0x38)
    snap();
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      uart_rx = 1'(8'h38 >> i);
      repeat (CPB) @(negedge clk);
    end
    uart_rx = 1'b1;
    repeat (300) @(negedge clk);
    Rst = 1'b1;
    repeat (2) @(negedge clk);
    check_val("mr_num", num, 0);
    check_val("mr_rx_byte", rx_byte, 0);
    repeat (CPB - 302) @(negedge clk);
    for (int i = 5; i < 8; i++) begin
      uart_rx = 1'(8'h38 >> i);
      repeat (CPB) @(negedge clk);
    end
    uart_rx = 1'b1;
    repeat (CPB) @(negedge clk);
    Rst = 1'b0;
    repeat (200) @(negedge clk);
    check_val("mr_nv_pulses", nv_cnt - nv0, 0);
    check_val("mr_rbv_pulses", rbv_cnt - rb0, 0);
    check_val("mr_frame_err", frame_err, 0);

    // '3' after reset
    snap();
    send_frame(8'h33, 1'b1);
    repeat (20) @(negedge clk);
    check_val("d3_num", num, 3);
    check_val("d3_rx_byte", rx_byte, 8'h33);
    check_val("d3_nv_pulses", nv_cnt - nv0, 1);

    check_val("consecutive_pulses", consec, 0);
    check_val("nv_without_rbv", unpaired, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
